fetch_unit_q: RTL

Parametrised next-generation fetch unit. It holds the fetch PC, issues word requests to instruction memory over a valid/ready handshake, and buffers returned {pc, inst} pairs in a small FIFO toward decode. It supports stall, PC-relative and absolute (register-based) redirects, in-flight response squashing, and a misaligned-target fault. It sits between the instruction memory port and the decode stage.

---
 rtl/fetch_unit_q_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 70 +++++++
 rtl/fetch_unit_q.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_q_pkg.sv
// rtl/fetch_unit_q_pkg.sv - shared types and constants for the fetch unit
//
// Purpose : FSM state encoding, instruction byte step and redirect mode
//           encodings used by fetch_unit_q.
// Ports   : none (package).
package fetch_unit_q_pkg;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,   // ready to issue a request at the fetch PC
      ST_WAIT  = 2'd1,   // one request outstanding, response will be kept
      ST_DRAIN = 2'd2    // one request outstanding, response will be dropped
   } fetch_state_e;

   // Byte distance between consecutive instruction words.
   localparam int unsigned INST_STEP = 4;

   // io_redir_mode encodings.
   localparam logic REDIR_REL = 1'b0;   // target = base + imm
   localparam logic REDIR_ABS = 1'b1;   // target = (base + imm) & ~1

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - parametrised synchronous FIFO with flush
//
// Purpose : small power-of-two deep FIFO, head presented combinationally.
// Ports   : clk_i, rst_i      clock and synchronous active-high reset
//           flush_i           empties the FIFO; a same-cycle push/pop is lost
//           push_i, data_i    write port (accepted when not full or popping)
//           pop_i             removes the head entry when valid_o
//           valid_o, data_o   head entry
//           full_o            DEPTH entries held
module fetch_queue #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    head_q;
   logic [AW-1:0]    tail_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign valid_o = (count_q != '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign data_o  = mem_q[head_q];

   // A pop frees the slot the push reuses, so push-when-full is fine with pop.
   assign do_pop  = pop_i && valid_o && !flush_i;
   assign do_push = push_i && (!full_o || do_pop) && !flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            tail_q <= tail_q + AW'(1);
         end
         if (do_pop) begin
            head_q <= head_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset: pointers define which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[tail_q] <= data_i;
      end
   end

endmodule

// File: rtl/fetch_unit_q.sv
// rtl/fetch_unit_q.sv - instruction fetch unit with redirect and fetch buffer
//
// Purpose : holds the fetch PC, issues one word request at a time to
//           instruction memory, buffers {pc, inst} pairs toward decode,
//           handles redirects, squashes in-flight responses and flags
//           misaligned redirect targets.
// Ports   : clock, reset                      clock, sync active-high reset
//           io_stall                          blocks new requests only
//           io_redir_valid/mode/base/imm      redirect request
//           io_req_valid/ready/addr           memory request handshake
//           io_resp_valid/inst                in-order memory response
//           io_out_valid/ready/pc/inst        fetch buffer head to decode
//           io_fault                          sticky misaligned-target flag
module fetch_unit_q #(
   parameter int unsigned      XLEN         = 32,
   parameter int unsigned      ILEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter int unsigned      QUEUE_DEPTH  = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_stall,
   input  logic            io_redir_valid,
   input  logic            io_redir_mode,
   input  logic [XLEN-1:0] io_redir_base,
   input  logic [XLEN-1:0] io_redir_imm,
   output logic            io_req_valid,
   input  logic            io_req_ready,
   output logic [XLEN-1:0] io_req_addr,
   input  logic            io_resp_valid,
   input  logic [ILEN-1:0] io_resp_inst,
   output logic            io_out_valid,
   input  logic            io_out_ready,
   output logic [XLEN-1:0] io_out_pc,
   output logic [ILEN-1:0] io_out_inst,
   output logic            io_fault
);

   import fetch_unit_q_pkg::*;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            fault_q, fault_d;

   logic [XLEN-1:0] redir_target;
   logic            req_fire;
   logic            q_push;
   logic            q_pop;
   logic            q_full;
   logic            q_valid;
   logic [XLEN+ILEN-1:0] q_head;

   always_comb begin
      redir_target = io_redir_base + io_redir_imm;
      if (io_redir_mode == REDIR_ABS) begin
         redir_target[0] = 1'b0;
      end
   end

   // Gated by reset so nothing is offered while the FSM is being initialised.
   assign io_req_valid = !reset && (state_q == ST_REQ) && !io_stall
                         && !fault_q && !q_full;
   assign io_req_addr  = pc_q;
   assign req_fire     = io_req_valid && io_req_ready;

   // A redirect flushes the buffer, so any same-cycle push or pop is lost.
   assign q_push = (state_q == ST_WAIT) && io_resp_valid && !io_redir_valid;
   assign q_pop  = q_valid && io_out_ready && !io_redir_valid;

   fetch_queue #(
      .WIDTH (XLEN + ILEN),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk_i   (clock),
      .rst_i   (reset),
      .flush_i (io_redir_valid),
      .push_i  (q_push),
      .data_i  ({inflight_pc_q, io_resp_inst}),
      .pop_i   (q_pop),
      .valid_o (q_valid),
      .data_o  (q_head),
      .full_o  (q_full)
   );

   assign io_out_valid = q_valid;
   assign {io_out_pc, io_out_inst} = q_head;
   assign io_fault = fault_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      fault_d       = fault_q;

      case (state_q)
         ST_REQ: begin
            // The PC only advances once the response is captured.
            if (req_fire) begin
               inflight_pc_d = pc_q;
               state_d       = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (io_resp_valid) begin
               pc_d    = inflight_pc_q + XLEN'(INST_STEP);
               state_d = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (io_resp_valid) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase

      if (io_redir_valid) begin
         pc_d    = redir_target;
         fault_d = (redir_target[1:0] != 2'b00);
         case (state_q)
            // A request accepted this cycle belongs to the old path.
            ST_REQ:  state_d = req_fire ? ST_DRAIN : ST_REQ;
            // Outstanding request: drop its response, now or later.
            default: state_d = io_resp_valid ? ST_REQ : ST_DRAIN;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_REQ;
         pc_q          <= RESET_VECTOR;
         inflight_pc_q <= RESET_VECTOR;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_pc_q <= inflight_pc_d;
         fault_q       <= fault_d;
      end
   end

endmodule
